// File: rtl/eth_vlg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : eth_vlg_pkg
// Purpose  : Byte-stream type shared by the Ethernet frame pipeline.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package eth_vlg_pkg;

  // One byte lane with framing flags
  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } stream_t;

endpackage : eth_vlg_pkg
`default_nettype wire

// File: rtl/mac_vlg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : mac_vlg_pkg
// Purpose  : MAC header metadata and the TX arbiter state encoding.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package mac_vlg_pkg;

  // Header fields the MAC needs to build the Ethernet header
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
  } mac_meta_t;

  // TX arbiter grant phases
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACC = 2'd1,
    ACTIVE   = 2'd2
  } arb_state_t;

endpackage : mac_vlg_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational round-robin priority encoder. Returns the first
//            set request at or after ptr, wrapping modulo N.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int  N   = 2,
  localparam int W_N = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [W_N-1:0] ptr,
  output logic [W_N-1:0] idx,
  output logic           vld
);

  logic [N-1:0] rot;   // requests rotated so bit 0 is the one at ptr
  logic [W_N:0] sum;   // ptr + offset before the modulo-N fold

  // Lowest set bit of the rotated vector wins; loop runs downward so it lands last
  always_comb begin
    rot = N'({req, req} >> ptr);
    idx = '0;
    vld = 1'b0;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        vld = 1'b1;
        sum = {1'b0, ptr} + (W_N + 1)'(k);
        idx = (sum >= (W_N + 1)'(N)) ? W_N'(sum - (W_N + 1)'(N)) : W_N'(sum);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mac_tx_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mac_tx_arb
// Purpose  : Round-robin arbiter sharing one MAC TX port among N frame
//            sources, with the grant locked for a full frame and a watchdog
//            that frees a grant the MAC never accepts or completes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module mac_tx_arb
  import eth_vlg_pkg::*;
  import mac_vlg_pkg::*;
#(
  parameter int  N       = 2,
  parameter int  TIMEOUT = 65535,
  localparam int W_N     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          src_rdy,
  input  stream_t [N-1:0]       src_strm,
  input  mac_meta_t [N-1:0]     src_meta,
  output logic [N-1:0]          src_req,
  output logic [N-1:0]          src_acc,
  output logic [N-1:0]          src_done,
  output logic                  mac_rdy,
  output stream_t               mac_strm,
  output mac_meta_t             mac_meta,
  input  logic                  mac_req,
  input  logic                  mac_acc,
  input  logic                  mac_done,
  output logic [N-1:0]          gnt,
  output logic                  busy,
  output logic                  tmo
);

  localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t     state, state_nxt;
  logic [W_N-1:0] g;          // index of the held grant
  logic [W_N-1:0] rr;         // search start for the next arbitration
  logic [W_N-1:0] pick_idx;
  logic           pick_vld;
  logic [WD_W-1:0] wd_cnt;
  logic           wd_hit;
  logic           release_gnt; // grant ends this cycle, rr moves past g
  logic           wd_fire;     // the ending is a watchdog release

  rr_pick #(.N(N)) u_rr_pick (
    .req (src_rdy),
    .ptr (rr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign wd_hit = (TIMEOUT != 0) && (state != IDLE) && (wd_cnt == WD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: MAC events beat a source abort, which beats the watchdog
  always_comb begin
    state_nxt   = state;
    release_gnt = 1'b0;
    wd_fire     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (mac_done)          release_gnt = 1'b1;
        else if (mac_acc)      state_nxt   = ACTIVE;
        else if (!src_rdy[g])  release_gnt = 1'b1;
        else if (wd_hit) begin
          release_gnt = 1'b1;
          wd_fire     = 1'b1;
        end
      end
      ACTIVE: begin
        if (mac_done) release_gnt = 1'b1;
        else if (wd_hit) begin
          release_gnt = 1'b1;
          wd_fire     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (release_gnt) state_nxt = IDLE;
  end

  // Outputs: forward the granted source to the MAC and route MAC strobes back
  always_comb begin
    busy     = (state != IDLE);
    mac_rdy  = (state == WAIT_ACC) && src_rdy[g];
    mac_strm = busy ? src_strm[g] : '0;
    mac_meta = busy ? src_meta[g] : '0;
    src_req  = '0;
    src_acc  = '0;
    src_done = '0;
    if (busy) begin
      src_req[g]  = mac_req;
      src_acc[g]  = mac_acc;
      src_done[g] = mac_done;
    end
  end

  // Grant, rr pointer, watchdog counter and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      g      <= '0;
      rr     <= '0;
      gnt    <= '0;
      wd_cnt <= '0;
      tmo    <= 1'b0;
    end else begin
      tmo <= wd_fire;
      if (state_nxt != state) wd_cnt <= '0;
      else if (state != IDLE) wd_cnt <= wd_cnt + WD_W'(1);
      if ((state == IDLE) && pick_vld) begin
        g   <= pick_idx;
        gnt <= N'(1) << pick_idx;
      end
      if (release_gnt) begin
        gnt <= '0;
        rr  <= (g == W_N'(N - 1)) ? '0 : g + W_N'(1);
      end
    end
  end

endmodule : mac_tx_arb
`default_nettype wire
